keccak_squeeze: RTL and testbench
=================================

Name: keccak_squeeze

Overview:
Output-side partner of the Keccak-f round datapath. Captures a permuted b-bit state and streams the rate portion out as w-bit lanes over a valid/ready interface. When more output is requested than one rate block holds, it sends the held state back to the iterative permutation engine and resumes streaming from the returned state. Used for SHA3 digests (fixed length) and SHAKE (extendable output).

Parameters:
l, 6, lane width log2
w, 2**l, lane width in bits
b, 25*w, state width in bits
RATE_LANES, 17, lanes per rate block (1..24), e.g. 17 for SHA3-256, 21 for SHAKE128
CNT_W, 16, width of the requested-lane counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  begin a squeeze; sampled only in IDLE
num_lanes  in  CNT_W  total lanes to output; sampled with start
s_valid  in  1  permuted state available
s_ready  out  1  block accepts a state
s_state  in  b  permuted state; lane k = i+5*j at bits [w*k +: w]
perm_req  out  1  request another permutation of perm_state
perm_state  out  b  held state returned to the permutation engine
m_data  out  w  output lane
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts
m_last  out  1  final lane of this squeeze, qualified by m_valid
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, active-high, any state): FSM -> IDLE; state register, lane index and remaining count cleared; s_ready, perm_req, m_valid, m_last and busy are 0; m_data and perm_state are 0.
- FSM states: IDLE, WAIT_STATE, EMIT.
- IDLE:
  - start=1 with num_lanes!=0: latch num_lanes into remaining; clear the first_block_done flag; go to WAIT_STATE.
  - start=1 with num_lanes=0: ignored; stay in IDLE.
- WAIT_STATE:
  - s_ready=1.
  - perm_req = first_block_done. It is 0 for the first block, which the absorbing side permutes. It stays high until the state is accepted.
  - On s_valid&&s_ready: register s_state, set lane index to 0, go to EMIT.
- EMIT:
  - m_valid=1; m_data = held lane[index], taken from the registered state.
  - First beat appears on the cycle after the state capture.
  - m_last = (remaining==1).
  - On m_valid&&m_ready:
    - decrement remaining and increment index;
    - if remaining was 1: go to IDLE (m_valid drops on the next cycle);
    - else if index was RATE_LANES-1: set first_block_done, go to WAIT_STATE;
    - else stay in EMIT.
- Backpressure: while m_ready=0, m_data, m_last and index are held stable. m_valid never drops without a handshake.
- perm_state always equals the held state register.
- start is ignored while busy. s_valid is ignored outside WAIT_STATE (s_ready=0).
- Throughput: one lane per cycle with m_ready held high. Each rate-block boundary costs one WAIT_STATE cycle plus the permutation engine latency.
- num_lanes is full-range unsigned. remaining never underflows.
- Lanes at index RATE_LANES..24 (capacity) are never output.

Optional Feature:
Macro KECCAK_SQUEEZE_BSWAP_EN.
- Defined: m_data is the held lane with byte order reversed (bits [7:0] of the lane appear at m_data[w-1:w-8]), for big-endian hex digest display; requires w a multiple of 8.
- Undefined: m_data is the lane unchanged (little-endian, FIPS 202 order).
- Handshake and timing are identical in both cases.

Test Plan:
- SHA3-256 config (RATE_LANES=17), num_lanes=4, s_state lane k = 64'h0000_0000_0000_00kk, m_ready=1 -> beats 0x00,0x01,0x02,0x03; m_last only on 0x03; perm_req never high; busy low on the cycle after the last beat.
- Backpressure: same stimulus, m_ready toggling 1,0,0,1,... -> m_data and m_last held stable while stalled; no lane dropped or repeated; exactly 4 handshakes.
- SHAKE128 config (RATE_LANES=21), num_lanes=25 -> 21 lanes 0x00..0x14, then perm_req=1 with perm_state equal to the captured state. Engine returns lane k = 0x100+k -> beats 0x100..0x103; m_last on 0x103.
- num_lanes=0 with start -> busy stays 0, s_ready stays 0. start pulsed while busy -> no effect on remaining count.
- Reset asserted mid-EMIT after 2 beats -> outputs 0 and IDLE immediately (asynchronous). A fresh start then outputs from lane 0.
- With KECCAK_SQUEEZE_BSWAP_EN defined, lane 0x0123456789ABCDEF -> m_data 0xEFCDAB8967452301.

Source files
------------

// File: rtl/keccak_squeeze_if.sv
// Stream bundle between keccak_squeeze, the permutation engine and the lane consumer.
// A transfer on either channel happens on a rising clk edge where valid && ready; valid never drops before that.
interface keccak_squeeze_if #(
   parameter int W = 64
);
   localparam int B = 25 * W;

   logic         s_valid;
   logic         s_ready;
   logic [B-1:0] s_state;
   logic         perm_req;
   logic [B-1:0] perm_state;
   logic [W-1:0] m_data;
   logic         m_valid;
   logic         m_ready;
   logic         m_last;

   modport master (
      output s_valid, s_state, m_ready,
      input  s_ready, perm_req, perm_state, m_data, m_valid, m_last
   );

   modport slave (
      input  s_valid, s_state, m_ready,
      output s_ready, perm_req, perm_state, m_data, m_valid, m_last
   );
endinterface

// File: rtl/keccak_squeeze.sv
// Keccak squeeze: captures a permuted state and streams rate lanes, looping back for more blocks.
// Optional macro KECCAK_SQUEEZE_BSWAP_EN byte-reverses each output lane for big-endian display.
module keccak_squeeze #(
   parameter int L          = 6,
   parameter int RATE_LANES = 17,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] num_lanes,
   output logic             busy,
   output logic [1:0]       dbg_state_o,
   keccak_squeeze_if.slave  sq
);
   localparam int W = 2 ** L;
   localparam int B = 25 * W;

   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] WAIT_STATE = 2'd1;
   localparam logic [1:0] EMIT       = 2'd2;
   localparam logic [4:0] LAST_IDX   = 5'(RATE_LANES - 1);

   logic [1:0]       state_q, state_d;
   logic [B-1:0]     held_q, held_d;
   logic [4:0]       idx_q, idx_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             first_done_q, first_done_d;
   logic [W-1:0]     lane_sel;

   always_comb begin
      lane_sel = '0;
      for (int k = 0; k < 25; k++) begin
         if (idx_q == 5'(k)) lane_sel = held_q[W*k +: W];
      end
   end

`ifdef KECCAK_SQUEEZE_BSWAP_EN
   always_comb begin
      sq.m_data = '0;
      for (int i = 0; i < W / 8; i++) begin
         sq.m_data[W-1-8*i -: 8] = lane_sel[8*i +: 8];
      end
   end
`else
   assign sq.m_data = lane_sel;
`endif

   assign sq.s_ready    = (state_q == WAIT_STATE);
   // The first block is permuted by the absorbing side, so only later blocks request the engine.
   assign sq.perm_req   = (state_q == WAIT_STATE) && first_done_q;
   assign sq.perm_state = held_q;
   assign sq.m_valid    = (state_q == EMIT);
   assign sq.m_last     = (state_q == EMIT) && (rem_q == CNT_W'(1));
   assign busy          = (state_q != IDLE);
   assign dbg_state_o   = state_q;

   always_comb begin
      state_d      = state_q;
      held_d       = held_q;
      idx_d        = idx_q;
      rem_d        = rem_q;
      first_done_d = first_done_q;
      case (state_q)
         IDLE: begin
            if (start && (num_lanes != '0)) begin
               rem_d        = num_lanes;
               first_done_d = 1'b0;
               state_d      = WAIT_STATE;
            end
         end
         WAIT_STATE: begin
            if (sq.s_valid) begin
               held_d  = sq.s_state;
               idx_d   = '0;
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (sq.m_ready) begin
               rem_d = rem_q - CNT_W'(1);
               idx_d = idx_q + 5'd1;
               if (rem_q == CNT_W'(1)) begin
                  state_d = IDLE;
               end else if (idx_q == LAST_IDX) begin
                  first_done_d = 1'b1;
                  state_d      = WAIT_STATE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         held_q       <= '0;
         idx_q        <= '0;
         rem_q        <= '0;
         first_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         held_q       <= held_d;
         idx_q        <= idx_d;
         rem_q        <= rem_d;
         first_done_q <= first_done_d;
      end
   end
endmodule

// File: tb/tb_keccak_squeeze.sv
// Bench for keccak_squeeze: two instances (rate 17 and rate 21) share stimulus; sel picks the one observed.
`timescale 1ns/1ps
module tb_keccak_squeeze;
   localparam int W = 64;
   localparam int B = 25 * W;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic         start = 1'b0;
   logic [15:0]  num_lanes = '0;
   logic         s_valid = 1'b0;
   logic [B-1:0] s_state = '0;
   logic         m_ready = 1'b0;
   logic         sel = 1'b0;

   logic       busy17, busy21;
   logic [1:0] dbg17, dbg21;

   keccak_squeeze_if #(.W(W)) if17 ();
   keccak_squeeze_if #(.W(W)) if21 ();

   assign if17.s_valid = s_valid;
   assign if17.s_state = s_state;
   assign if17.m_ready = m_ready;
   assign if21.s_valid = s_valid;
   assign if21.s_state = s_state;
   assign if21.m_ready = m_ready;

   keccak_squeeze #(.L(6), .RATE_LANES(17), .CNT_W(16)) dut17 (
      .clk(clk), .reset(reset), .start(start), .num_lanes(num_lanes),
      .busy(busy17), .dbg_state_o(dbg17), .sq(if17)
   );
   keccak_squeeze #(.L(6), .RATE_LANES(21), .CNT_W(16)) dut21 (
      .clk(clk), .reset(reset), .start(start), .num_lanes(num_lanes),
      .busy(busy21), .dbg_state_o(dbg21), .sq(if21)
   );

   logic         o_s_ready, o_perm_req, o_m_valid, o_m_last, o_busy;
   logic [B-1:0] o_perm_state;
   logic [W-1:0] o_m_data;
   logic [1:0]   o_dbg;

   always_comb begin
      if (sel) begin
         o_s_ready = if21.s_ready;  o_perm_req = if21.perm_req;   o_m_valid = if21.m_valid;
         o_m_last  = if21.m_last;   o_perm_state = if21.perm_state; o_m_data = if21.m_data;
         o_busy    = busy21;        o_dbg = dbg21;
      end else begin
         o_s_ready = if17.s_ready;  o_perm_req = if17.perm_req;   o_m_valid = if17.m_valid;
         o_m_last  = if17.m_last;   o_perm_state = if17.perm_state; o_m_data = if17.m_data;
         o_busy    = busy17;        o_dbg = dbg17;
      end
   end

   int total = 0;
   int bad = 0;
   logic [W-1:0] exp_q[$];
   logic [B-1:0] st_arr[8];

   // Reference: a lane of a state, as the consumer should see it.
   function automatic logic [W-1:0] model_lane(input logic [B-1:0] s, input int k);
      logic [W-1:0] v;
      logic [W-1:0] r;
      v = s[W*k +: W];
`ifdef KECCAK_SQUEEZE_BSWAP_EN
      r = '0;
      for (int i = 0; i < W / 8; i++) r[W-8-8*i +: 8] = v[8*i +: 8];
`else
      r = v;
`endif
      return r;
   endfunction

   task automatic pulse_reset();
      @(negedge clk);
      start = 1'b0; s_valid = 1'b0; m_ready = 1'b0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // kind 0: lane k of block bl = 0x100*bl + k; kind 1: random; kind 2: random with lane0 of block 0 fixed.
   task automatic do_squeeze(input int n, input int rate, input int kind, input bit stall, input bit poke);
      int nblk, blk, hs, cyc;
      bit stalled, poked;
      logic [W-1:0] held_data, got, exp;
      logic held_last, exp_last;
      nblk = (n + rate - 1) / rate;
      for (int bl = 0; bl < nblk; bl++) begin
         for (int k = 0; k < 25; k++) begin
            if (kind == 0) st_arr[bl][W*k +: W] = 64'(bl * 256 + k);
            else           st_arr[bl][W*k +: W] = {$urandom, $urandom};
         end
      end
      if (kind == 2) st_arr[0][W-1:0] = 64'h0123_4567_89AB_CDEF;
      exp_q.delete();
      for (int j = 0; j < n; j++) exp_q.push_back(model_lane(st_arr[j / rate], j % rate));
      @(negedge clk);
      start = 1'b1; num_lanes = 16'(n);
      @(negedge clk);
      start = 1'b0;
      blk = 0; hs = 0; cyc = 0; stalled = 0; poked = 0;
      held_data = '0; held_last = 1'b0;
      while (hs < n && cyc < 3000) begin
         s_valid = 1'b0;
         start = 1'b0;
         if (poke && !poked && o_busy) begin
            start = 1'b1; num_lanes = 16'(n + 7); poked = 1;
         end
         if (o_s_ready) begin
            total++;
            if (o_perm_req !== (blk > 0)) begin
               bad++; $display("FAIL perm_req blk=%0d: got %b expected %b", blk, o_perm_req, (blk > 0));
            end
            if (blk > 0) begin
               total++;
               if (o_perm_state !== st_arr[blk-1]) begin
                  bad++; $display("FAIL perm_state blk=%0d: got lane0 %h expected lane0 %h",
                                  blk, o_perm_state[W-1:0], st_arr[blk-1][W-1:0]);
               end
            end
            if (blk < nblk) begin
               s_valid = 1'b1; s_state = st_arr[blk]; blk++;
            end
         end else begin
            total++;
            if (o_perm_req !== 1'b0) begin
               bad++; $display("FAIL perm_req_idle: got %b expected 0", o_perm_req);
            end
         end
         if (o_m_valid) begin
            if (stalled) begin
               total++;
               if (o_m_data !== held_data || o_m_last !== held_last) begin
                  bad++; $display("FAIL stall_hold: got %h/%b expected %h/%b", o_m_data, o_m_last, held_data, held_last);
               end
            end
            if (stall) m_ready = (cyc % 3 == 0);
            else if (kind == 1) m_ready = ($urandom_range(0, 3) != 0);
            else m_ready = 1'b1;
            if (m_ready) begin
               got = o_m_data;
               exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
               exp_last = (exp_q.size() == 0);
               total++;
               if (got !== exp) begin
                  bad++; $display("FAIL m_data beat=%0d: got %h expected %h", hs, got, exp);
               end
               total++;
               if (o_m_last !== exp_last) begin
                  bad++; $display("FAIL m_last beat=%0d: got %b expected %b", hs, o_m_last, exp_last);
               end
               hs++;
               stalled = 0;
            end else begin
               stalled = 1; held_data = o_m_data; held_last = o_m_last;
            end
         end else begin
            m_ready = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
      total++;
      if (hs != n) begin
         bad++; $display("FAIL beat_count: got %0d expected %0d (cycle budget)", hs, n);
      end
      total++;
      if (o_busy !== 1'b0 || o_m_valid !== 1'b0) begin
         bad++; $display("FAIL end_idle: got busy=%b m_valid=%b expected 0/0", o_busy, o_m_valid);
      end
   endtask

   task automatic test_reset();
      for (int s = 0; s < 2; s++) begin
         sel = s[0];
         #1;
         total++;
         if ({o_s_ready, o_perm_req, o_m_valid, o_m_last, o_busy} !== 5'b0 || o_m_data !== '0 ||
             o_perm_state !== '0 || o_dbg !== 2'd0) begin
            bad++; $display("FAIL reset_state sel=%0d: got flags %b data %h expected zeros", s,
                            {o_s_ready, o_perm_req, o_m_valid, o_m_last, o_busy}, o_m_data);
         end
      end
      sel = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sha3_basic();
      sel = 1'b0; pulse_reset();
      do_squeeze(4, 17, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      sel = 1'b0; pulse_reset();
      do_squeeze(4, 17, 0, 1, 0);
   endtask

   task automatic test_shake_multiblock();
      sel = 1'b1; pulse_reset();
      do_squeeze(25, 21, 0, 0, 0);
   endtask

   task automatic test_zero_and_busy_start();
      sel = 1'b0; pulse_reset();
      @(negedge clk);
      start = 1'b1; num_lanes = '0;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
         total++;
         if (o_busy !== 1'b0 || o_s_ready !== 1'b0) begin
            bad++; $display("FAIL zero_lanes: got busy=%b s_ready=%b expected 0/0", o_busy, o_s_ready);
         end
         @(negedge clk);
      end
      do_squeeze(3, 17, 1, 0, 1);
   endtask

   task automatic test_reset_mid_emit();
      int c;
      sel = 1'b0; pulse_reset();
      for (int k = 0; k < 25; k++) st_arr[0][W*k +: W] = 64'(k);
      @(negedge clk);
      start = 1'b1; num_lanes = 16'd10;
      @(negedge clk);
      start = 1'b0;
      c = 0;
      while (!o_s_ready && c < 10) begin @(negedge clk); c++; end
      total++;
      if (o_s_ready !== 1'b1) begin
         bad++; $display("FAIL mid_wait: got s_ready=%b expected 1", o_s_ready);
      end
      s_valid = 1'b1; s_state = st_arr[0];
      @(negedge clk);
      s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      m_ready = 1'b0;
      total++;
      if (o_m_valid !== 1'b1 || o_m_data !== model_lane(st_arr[0], 2)) begin
         bad++; $display("FAIL mid_beat2: got v=%b %h expected v=1 %h", o_m_valid, o_m_data, model_lane(st_arr[0], 2));
      end
      #2 reset = 1'b1;
      #1;
      total++;
      if ({o_s_ready, o_perm_req, o_m_valid, o_m_last, o_busy} !== 5'b0 || o_m_data !== '0 ||
          o_perm_state !== '0 || o_dbg !== 2'd0) begin
         bad++; $display("FAIL async_reset: got flags %b data %h expected zeros",
                         {o_s_ready, o_perm_req, o_m_valid, o_m_last, o_busy}, o_m_data);
      end
      @(negedge clk);
      reset = 1'b0;
      do_squeeze(3, 17, 0, 0, 0);
   endtask

   task automatic test_bswap();
      logic [W-1:0] want;
      sel = 1'b0; pulse_reset();
      do_squeeze(1, 17, 2, 0, 0);
      // Independent check of the first lane against the literal digest order.
`ifdef KECCAK_SQUEEZE_BSWAP_EN
      want = 64'hEFCD_AB89_6745_2301;
`else
      want = 64'h0123_4567_89AB_CDEF;
`endif
      total++;
      if (model_lane(st_arr[0], 0) !== want) begin
         bad++; $display("FAIL bswap_model: got %h expected %h", model_lane(st_arr[0], 0), want);
      end
   endtask

   task automatic test_random();
      int n, rate;
      for (int t = 0; t < 5; t++) begin
         sel = 1'($urandom_range(0, 1));
         rate = sel ? 21 : 17;
         n = $urandom_range(1, 45);
         pulse_reset();
         do_squeeze(n, rate, 1, 0, 0);
      end
   endtask

   initial begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      test_reset();
      test_sha3_basic();
      test_backpressure();
      test_shake_multiblock();
      test_zero_and_busy_start();
      test_reset_mid_emit();
      test_bswap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
